// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types and defaults for the systolic matrix-multiply engine
package systolic_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DRAIN  = 2'd3
  } state_e;

  typedef logic signed [DEF_DATA_W-1:0] operand_t;
  typedef logic signed [DEF_ACC_W-1:0]  acc_t;

endpackage

// File: rtl/pe_mac.sv
// rtl/pe_mac.sv - systolic processing element: registered operand pass-through and signed MAC
module pe_mac #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [DATA_W-1:0] a_o,
  output logic signed [DATA_W-1:0] b_o,
  output logic signed [ACC_W-1:0]  acc_o
);

  logic signed [DATA_W-1:0]   a_q;
  logic signed [DATA_W-1:0]   b_q;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [ACC_W-1:0]    acc_d;
  logic signed [2*DATA_W-1:0] prod;

  // Operands are widened before multiplying so the full signed product is kept.
  assign prod  = (2*DATA_W)'(a_i) * (2*DATA_W)'(b_i);
  assign acc_d = clr_i ? '0 : acc_q + ACC_W'(prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_i;
      b_q   <= b_i;
      acc_q <= acc_d;
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;

endmodule

// File: rtl/systolic_mm_engine.sv
// rtl/systolic_mm_engine.sv - output-stationary ROWS x COLS signed systolic matrix-multiply engine
module systolic_mm_engine
  import systolic_pkg::*;
#(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int K_W    = 16
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          start,
  input  logic [K_W-1:0]                                k_len,
  output logic                                          busy,
  input  logic                                          a_valid,
  output logic                                          a_ready,
  input  logic [ROWS*DATA_W-1:0]                        a_col,
  input  logic [COLS*DATA_W-1:0]                        b_row,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0]    out_row_idx,
  output logic [COLS*ACC_W-1:0]                         out_data,
  output logic                                          done
);

  localparam int RIDX_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int FLUSH_CYC = ROWS + COLS - 1;
  localparam int FCNT_W    = $clog2(FLUSH_CYC + 1);

  state_e              state_q, state_d;
  logic [K_W-1:0]      k_len_q, k_len_d;
  logic [K_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic [FCNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [RIDX_W-1:0]   row_q, row_d;
  logic                done_q, done_d;
  logic                launch;
  logic                beat;

  assign launch = (state_q == ST_IDLE) && start && (k_len != '0);
  assign beat   = (state_q == ST_STREAM) && a_valid;

  always_comb begin
    state_d     = state_q;
    k_len_d     = k_len_q;
    beat_cnt_d  = beat_cnt_q;
    flush_cnt_d = flush_cnt_q;
    row_d       = row_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          state_d    = ST_STREAM;
          k_len_d    = k_len;
          beat_cnt_d = '0;
        end
      end
      ST_STREAM: begin
        // Compare against k_len-1 so a depth of 2^K_W-1 never needs the counter to wrap.
        if (a_valid) begin
          if (beat_cnt_q == k_len_q - K_W'(1)) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + K_W'(1);
          end
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == FCNT_W'(FLUSH_CYC - 1)) begin
          state_d = ST_DRAIN;
          row_d   = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + FCNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (row_q == RIDX_W'(ROWS - 1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            row_d   = '0;
          end else begin
            row_d = row_q + RIDX_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      k_len_q     <= '0;
      beat_cnt_q  <= '0;
      flush_cnt_q <= '0;
      row_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_len_q     <= k_len_d;
      beat_cnt_q  <= beat_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      row_q       <= row_d;
      done_q      <= done_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign a_ready     = (state_q == ST_STREAM);
  assign out_valid   = (state_q == ST_DRAIN);
  assign out_row_idx = row_q;
  assign done        = done_q;

  // Anything that is not an accepted beat enters the array as a zero bubble.
  logic signed [DATA_W-1:0] a_in  [ROWS];
  logic signed [DATA_W-1:0] b_in  [COLS];
  logic signed [DATA_W-1:0] west  [ROWS];
  logic signed [DATA_W-1:0] north [COLS];

  genvar gi, gj;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_ain
      assign a_in[gi] = beat ? a_col[gi*DATA_W +: DATA_W] : '0;
    end
    for (gj = 0; gj < COLS; gj++) begin : g_bin
      assign b_in[gj] = beat ? b_row[gj*DATA_W +: DATA_W] : '0;
    end

    for (gi = 0; gi < ROWS; gi++) begin : g_askew
      if (gi == 0) begin : g_nodly
        assign west[0] = a_in[0];
      end else begin : g_dly
        logic signed [DATA_W-1:0] sr_q [gi];
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            for (int d = 0; d < gi; d++) sr_q[d] <= '0;
          end else begin
            sr_q[0] <= a_in[gi];
            for (int d = 1; d < gi; d++) sr_q[d] <= sr_q[d-1];
          end
        end
        assign west[gi] = sr_q[gi-1];
      end
    end

    for (gj = 0; gj < COLS; gj++) begin : g_bskew
      if (gj == 0) begin : g_nodly
        assign north[0] = b_in[0];
      end else begin : g_dly
        logic signed [DATA_W-1:0] sr_q [gj];
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            for (int d = 0; d < gj; d++) sr_q[d] <= '0;
          end else begin
            sr_q[0] <= b_in[gj];
            for (int d = 1; d < gj; d++) sr_q[d] <= sr_q[d-1];
          end
        end
        assign north[gj] = sr_q[gj-1];
      end
    end
  endgenerate

  logic signed [DATA_W-1:0] a_h    [ROWS][COLS+1];
  logic signed [DATA_W-1:0] b_v    [ROWS+1][COLS];
  logic signed [ACC_W-1:0]  acc_w  [ROWS][COLS];
  logic [ROWS*DATA_W-1:0]   east_edge;
  logic [COLS*DATA_W-1:0]   south_edge;
  logic                     unused_edge;

  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      assign a_h[gi][0] = west[gi];
      assign east_edge[gi*DATA_W +: DATA_W] = a_h[gi][COLS];
      for (gj = 0; gj < COLS; gj++) begin : g_col
        pe_mac #(
          .DATA_W (DATA_W),
          .ACC_W  (ACC_W)
        ) u_pe (
          .clk   (clk),
          .rst_n (rst_n),
          .clr_i (launch),
          .a_i   (a_h[gi][gj]),
          .b_i   (b_v[gi][gj]),
          .a_o   (a_h[gi][gj+1]),
          .b_o   (b_v[gi+1][gj]),
          .acc_o (acc_w[gi][gj])
        );
      end
    end
    for (gj = 0; gj < COLS; gj++) begin : g_edge
      assign b_v[0][gj] = north[gj];
      assign south_edge[gj*DATA_W +: DATA_W] = b_v[ROWS][gj];
    end
  endgenerate

  // Operands leaving the far edges of the grid have no consumer.
  assign unused_edge = ^{east_edge, south_edge};

  always_comb begin
    out_data = '0;
    if (state_q == ST_DRAIN) begin
      for (int j = 0; j < COLS; j++) out_data[j*ACC_W +: ACC_W] = acc_w[row_q][j];
    end
  end

endmodule

// File: tb/tb_systolic_mm_engine.sv
// tb/tb_systolic_mm_engine.sv - scoreboard bench for systolic_mm_engine
module tb_systolic_mm_engine;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 32;
  localparam int ACC16  = 16;
  localparam int K_W    = 16;

  logic                     clk;
  logic                     rst_n;
  logic                     start, start16;
  logic [K_W-1:0]           k_len;
  logic                     a_valid;
  logic [ROWS*DATA_W-1:0]   a_col;
  logic [COLS*DATA_W-1:0]   b_row;
  logic                     out_ready;

  logic                     busy, a_ready, out_valid, done;
  logic [1:0]               out_row_idx;
  logic [COLS*ACC_W-1:0]    out_data;
  logic                     busy16, a_ready16, out_valid16, done16;
  logic [1:0]               out_row_idx16;
  logic [COLS*ACC16-1:0]    out_data16;

  systolic_mm_engine #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ACC_W(ACC_W), .K_W(K_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .busy(busy),
    .a_valid(a_valid), .a_ready(a_ready), .a_col(a_col), .b_row(b_row),
    .out_valid(out_valid), .out_ready(out_ready), .out_row_idx(out_row_idx),
    .out_data(out_data), .done(done)
  );

  systolic_mm_engine #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ACC_W(ACC16), .K_W(K_W)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .k_len(k_len), .busy(busy16),
    .a_valid(a_valid), .a_ready(a_ready16), .a_col(a_col), .b_row(b_row),
    .out_valid(out_valid16), .out_ready(out_ready), .out_row_idx(out_row_idx16),
    .out_data(out_data16), .done(done16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic                  sel16;
  logic                  ov, odone, obusy, ordy;
  logic [1:0]            oidx;
  logic [COLS*ACC_W-1:0] od;
  assign ov    = sel16 ? out_valid16   : out_valid;
  assign odone = sel16 ? done16        : done;
  assign obusy = sel16 ? busy16        : busy;
  assign ordy  = sel16 ? a_ready16     : a_ready;
  assign oidx  = sel16 ? out_row_idx16 : out_row_idx;
  assign od    = sel16 ? {{(COLS*(ACC_W-ACC16)){1'b0}}, out_data16} : out_data;

  int n_cmp = 0;
  int n_err = 0;
  int am [ROWS][16];
  int bm [16][COLS];
  int                    sb_idx[$];
  logic [COLS*ACC_W-1:0] sb_data[$];

  task automatic clear_mats();
    for (int i = 0; i < ROWS; i++) for (int x = 0; x < 16; x++) am[i][x] = 0;
    for (int x = 0; x < 16; x++) for (int j = 0; j < COLS; j++) bm[x][j] = 0;
  endtask

  task automatic fill_scenario1();
    clear_mats();
    for (int i = 0; i < ROWS; i++) am[i][i] = 1;
    for (int x = 0; x < 4; x++) for (int j = 0; j < COLS; j++) bm[x][j] = 4*x + j + 1;
  endtask

  // Runs one job: pushes expected rows, streams beats, drains with scoreboard checks.
  task automatic run_job(input int k, input bit gaps, input int stall_cyc, input bit use16,
                         input bit poke, input int exp_lat, input string tag);
    logic [COLS*ACC_W-1:0] e, hdata;
    longint s;
    int t0, kk, guard, stall_left;
    bit first, holding, ph;
    logic [1:0] hidx;
    sel16 = use16;
    for (int i = 0; i < ROWS; i++) begin
      e = '0;
      for (int j = 0; j < COLS; j++) begin
        s = 0;
        for (int x = 0; x < k; x++) s += longint'(am[i][x]) * longint'(bm[x][j]);
        if (use16) e[j*ACC16 +: ACC16] = s[15:0];
        else       e[j*ACC_W +: ACC_W] = s[31:0];
      end
      sb_idx.push_back(i);
      sb_data.push_back(e);
    end
    @(posedge clk); #1;
    k_len = K_W'(k);
    if (use16) start16 = 1'b1; else start = 1'b1;
    @(negedge clk); t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0; start16 = 1'b0;
    kk = 0; ph = 1'b0; guard = 0;
    while (kk < k && guard < 200) begin
      guard++;
      if (gaps && ph) begin
        a_valid = 1'b0; a_col = '0; b_row = '0;
      end else begin
        a_valid = 1'b1;
        for (int i = 0; i < ROWS; i++) a_col[i*DATA_W +: DATA_W] = DATA_W'(am[i][kk]);
        for (int j = 0; j < COLS; j++) b_row[j*DATA_W +: DATA_W] = DATA_W'(bm[kk][j]);
      end
      ph = !ph;
      @(negedge clk);
      n_cmp++;
      if (ordy !== 1'b1) begin n_err++; $display("FAIL %s a_ready beat %0d: got %b want 1", tag, kk, ordy); end
      if (a_valid) kk++;
      @(posedge clk); #1;
    end
    a_valid = 1'b0; a_col = '0; b_row = '0;
    @(negedge clk);
    n_cmp++;
    if ({obusy, ordy, ov} !== 3'b100) begin
      n_err++; $display("FAIL %s flush state busy/a_ready/out_valid: got %b want 100", tag, {obusy, ordy, ov});
    end
    first = 1'b1; holding = 1'b0; stall_left = stall_cyc; guard = 0;
    out_ready = 1'b0;
    while (sb_idx.size() > 0 && guard < 300) begin
      @(negedge clk);
      guard++;
      if (poke && !first) start = 1'b0;
      if (ov) begin
        if (first) begin
          first = 1'b0;
          if (exp_lat >= 0) begin
            n_cmp++;
            if (cyc - t0 != exp_lat) begin
              n_err++; $display("FAIL %s first out_valid latency: got %0d want %0d", tag, cyc - t0, exp_lat);
            end
          end
          if (poke) begin start = 1'b1; k_len = 16'd2; end
        end
        n_cmp++;
        if (odone !== 1'b0) begin n_err++; $display("FAIL %s done during drain: got %b want 0", tag, odone); end
        if (holding) begin
          n_cmp++;
          if (oidx !== hidx || od !== hdata) begin
            n_err++; $display("FAIL %s stall hold: got idx %0d data %h want idx %0d data %h", tag, oidx, od, hidx, hdata);
          end
        end
        if (stall_left > 0 && oidx == 2'd1) begin
          if (!holding) begin holding = 1'b1; hidx = oidx; hdata = od; end
          stall_left--;
          out_ready = 1'b0;
        end else begin
          holding = 1'b0;
          n_cmp++;
          if (oidx !== 2'(sb_idx[0]) || od !== sb_data[0]) begin
            n_err++; $display("FAIL %s row: got idx %0d data %h want idx %0d data %h", tag, oidx, od, sb_idx[0], sb_data[0]);
          end
          void'(sb_idx.pop_front());
          void'(sb_data.pop_front());
          out_ready = 1'b1;
        end
      end else begin
        out_ready = 1'b0;
      end
    end
    if (guard >= 300) begin
      n_cmp++; n_err++;
      $display("FAIL %s drain timeout: got %0d rows left want 0", tag, sb_idx.size());
      sb_idx.delete(); sb_data.delete();
    end
    @(negedge clk);
    out_ready = 1'b0; start = 1'b0;
    n_cmp++;
    if ({odone, ov, obusy} !== 3'b100) begin
      n_err++; $display("FAIL %s done/out_valid/busy after last row: got %b want 100", tag, {odone, ov, obusy});
    end
    @(negedge clk);
    n_cmp++;
    if (odone !== 1'b0) begin n_err++; $display("FAIL %s done pulse width: got %b want 0", tag, odone); end
    sel16 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, a_ready, out_valid, done, out_row_idx} !== 6'b0 || out_data !== '0) begin
      n_err++; $display("FAIL reset outputs: got %b data %h want 0", {busy, a_ready, out_valid, done, out_row_idx}, out_data);
    end
    n_cmp++;
    if ({busy16, out_valid16, done16} !== 3'b0 || out_data16 !== '0) begin
      n_err++; $display("FAIL reset outputs acc16: got %b data %h want 0", {busy16, out_valid16, done16}, out_data16);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_identity();
    fill_scenario1();
    run_job(4, 1'b0, 0, 1'b0, 1'b0, 12, "identity");
  endtask

  task automatic test_extremes();
    clear_mats();
    for (int i = 0; i < ROWS; i++) for (int x = 0; x < 4; x++) am[i][x] = -128;
    for (int x = 0; x < 4; x++) for (int j = 0; j < COLS; j++) bm[x][j] = -128;
    run_job(4, 1'b0, 0, 1'b0, 1'b0, 12, "neg_neg");
    for (int x = 0; x < 4; x++) for (int j = 0; j < COLS; j++) bm[x][j] = 127;
    run_job(4, 1'b0, 0, 1'b0, 1'b0, 12, "neg_pos");
  endtask

  task automatic test_bubbles();
    fill_scenario1();
    run_job(4, 1'b1, 0, 1'b0, 1'b0, 15, "bubbles");
  endtask

  task automatic test_backpressure();
    fill_scenario1();
    run_job(4, 1'b0, 3, 1'b0, 1'b0, 12, "backpressure");
  endtask

  task automatic test_acc16_wrap();
    clear_mats();
    for (int i = 0; i < ROWS; i++) for (int x = 0; x < 8; x++) am[i][x] = 127;
    for (int x = 0; x < 8; x++) for (int j = 0; j < COLS; j++) bm[x][j] = 127;
    run_job(8, 1'b0, 0, 1'b1, 1'b0, 16, "acc16_wrap");
  endtask

  task automatic test_reset_mid_job();
    bit seen;
    fill_scenario1();
    @(posedge clk); #1;
    k_len = 16'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      a_valid = 1'b1;
      for (int i = 0; i < ROWS; i++) a_col[i*DATA_W +: DATA_W] = DATA_W'(am[i][b]);
      for (int j = 0; j < COLS; j++) b_row[j*DATA_W +: DATA_W] = DATA_W'(bm[b][j]);
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    a_valid = 1'b0; a_col = '0; b_row = '0;
    #1;
    n_cmp++;
    if ({busy, a_ready, out_valid, done, out_row_idx} !== 6'b0 || out_data !== '0) begin
      n_err++; $display("FAIL mid-job reset outputs: got %b data %h want 0", {busy, a_ready, out_valid, done, out_row_idx}, out_data);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid || busy || done) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin n_err++; $display("FAIL post-reset activity: got %b want 0", seen); end
  endtask

  task automatic test_small_job_and_ignored_starts();
    clear_mats();
    am[0][0] = 3;
    bm[0][0] = 5;
    run_job(1, 1'b0, 0, 1'b0, 1'b1, 9, "small_job");
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL start in drain ignored: got busy %b want 0", busy); end
    @(posedge clk); #1;
    k_len = '0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, a_ready} !== 2'b00) begin n_err++; $display("FAIL k_len=0 start ignored: got %b want 00", {busy, a_ready}); end
  endtask

  initial begin
    start = 1'b0; start16 = 1'b0; k_len = '0; a_valid = 1'b0;
    a_col = '0; b_row = '0; out_ready = 1'b0; sel16 = 1'b0;
    test_reset();
    test_identity();
    test_extremes();
    test_bubbles();
    test_backpressure();
    test_acc16_wrap();
    test_reset_mid_job();
    test_small_job_and_ignored_starts();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
